// File: rtl/tick_scheduler.sv
// tick_scheduler: free-running prescaler producing a one-cycle base tick, plus NCH
// software-armed countdown timers (one-shot or periodic). All channels share a single
// decrementer: each base tick launches a sweep that visits one channel per clock in
// index order. tick_1ms and expire are clock enables on clk, never clocks.
module tick_scheduler #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NCH     = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(NCH)-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]         cmd_period,
  output logic                     tick_1ms,
  output logic [NCH-1:0]           expire,
  output logic [NCH-1:0]           active
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CH_W     = $clog2(NCH);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_ONE   = 2'b01;
  localparam logic [1:0] OP_PER   = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t              state_r;
  logic [CH_W-1:0]     idx_r;
  logic [PW-1:0]       pcnt_r;
  logic                tick_r;
  logic [NCH-1:0]      expire_r;
  logic [NCH-1:0]      active_r;
  logic [NCH-1:0]      mode_r;          // 1 = periodic, 0 = one-shot
  logic [CNT_W-1:0]    cnt_r    [NCH];
  logic [CNT_W-1:0]    period_r [NCH];

  logic                cmd_ready_s;
  logic                cmd_fire_s;
  logic                ch_ok_s;
  logic [CH_W:0]       ch_ext_s;

  // Handshake: commands are only taken while idle and not on a tick cycle, so a
  // command never races the sweep over the channel state.
  always_comb begin
    cmd_ready_s = 1'b0;
    ch_ext_s    = {1'b0, cmd_ch};
    ch_ok_s     = (ch_ext_s < (CH_W + 1)'(NCH));
    if (rst_n && (state_r == IDLE) && !tick_r) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = 1'b0;
    end
    cmd_fire_s = cmd_valid & cmd_ready_s;
  end

  // Prescaler: pcnt wraps at PRESCALE-1 and the registered tick follows one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_r <= '0;
      tick_r <= 1'b0;
    end else begin
      tick_r <= (pcnt_r == PW'(PRESCALE - 1));
      if (pcnt_r == PW'(PRESCALE - 1)) begin
        pcnt_r <= '0;
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
      end
    end
  end

  // Sweep FSM plus channel state: commands apply in IDLE, countdown applies in SWEEP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      idx_r    <= '0;
      expire_r <= '0;
      active_r <= '0;
      mode_r   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_r[i]    <= '0;
        period_r[i] <= '0;
      end
    end else begin
      expire_r <= '0;
      case (state_r)
        IDLE: begin
          idx_r <= '0;
          if (tick_r) begin
            state_r <= SWEEP;
          end else begin
            state_r <= IDLE;
          end
          if (cmd_fire_s && ch_ok_s) begin
            case (cmd_op)
              OP_ONE, OP_PER: begin
                if (cmd_period != '0) begin
                  cnt_r[cmd_ch]    <= cmd_period;
                  period_r[cmd_ch] <= cmd_period;
                  mode_r[cmd_ch]   <= (cmd_op == OP_PER);
                  active_r[cmd_ch] <= 1'b1;
                end else begin
                  // A zero period behaves as a stop.
                  cnt_r[cmd_ch]    <= '0;
                  active_r[cmd_ch] <= 1'b0;
                end
              end
              OP_STOP: begin
                cnt_r[cmd_ch]    <= '0;
                active_r[cmd_ch] <= 1'b0;
              end
              OP_NOP: begin
                active_r <= active_r;
              end
              default: begin
                active_r <= active_r;
              end
            endcase
          end
        end
        SWEEP: begin
          if (active_r[idx_r]) begin
            if (cnt_r[idx_r] > CNT_W'(1)) begin
              cnt_r[idx_r] <= cnt_r[idx_r] - CNT_W'(1);
            end else begin
              expire_r[idx_r] <= 1'b1;
              if (mode_r[idx_r]) begin
                cnt_r[idx_r] <= period_r[idx_r];
              end else begin
                cnt_r[idx_r]    <= '0;
                active_r[idx_r] <= 1'b0;
              end
            end
          end
          if (idx_r == CH_W'(NCH - 1)) begin
            idx_r   <= '0;
            state_r <= IDLE;
          end else begin
            idx_r   <= idx_r + CH_W'(1);
            state_r <= SWEEP;
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= '0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_s;
  assign tick_1ms  = tick_r;
  assign expire    = expire_r;
  assign active    = active_r;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: a tick-level reference model pushes expected
// expiries into a queue; a negedge monitor compares tick/ready/active every cycle and pops
// the queue whenever the DUT pulses expire.
module tb_tick_scheduler;

  localparam int PRE = 10;
  localparam int NCH = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_ch;
  logic [7:0]  cmd_period;
  logic        tick_1ms;
  logic [3:0]  expire;
  logic [3:0]  active;

  tick_scheduler #(.CLK_HZ(100), .TICK_HZ(10), .NCH(NCH), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_period(cmd_period),
    .tick_1ms(tick_1ms), .expire(expire), .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int n; int ch; } ev_t;
  ev_t q[$];

  int compared = 0;
  int mismatched = 0;
  int n = 0;              // cycles since reset release (0 = first released cycle)
  bit armed = 0;
  logic [3:0] mact = '0;
  int rem [NCH];
  int per [NCH];
  bit mper [NCH];
  int clr_at [NCH];
  int obs [NCH];

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, n, $time);
    end
  endtask

  function automatic bit tick_exp(input int nn);
    return (nn > 0) && (nn % PRE == 0);
  endfunction

  function automatic bit ready_exp(input int nn);
    return (nn < PRE) || (nn % PRE > NCH);
  endfunction

  // Reference model: works in units of base ticks and remaining counts.
  initial begin
    for (int k = 0; k < NCH; k++) begin clr_at[k] = -1; obs[k] = 0; rem[k] = 0; per[k] = 0; mper[k] = 0; end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        armed = 1;
        n = 0;
        mact = '0;
        q.delete();
        for (int k = 0; k < NCH; k++) clr_at[k] = -1;
      end else begin
        if (tick_exp(n)) begin
          for (int k = 0; k < NCH; k++) begin
            if (mact[k] && clr_at[k] < 0) begin
              ev_t e;
              rem[k] = rem[k] - 1;
              if (rem[k] == 0) begin
                e.n = n + 2 + k;
                e.ch = k;
                q.push_back(e);
                if (mper[k]) rem[k] = per[k];
                else clr_at[k] = n + 2 + k;
              end
            end
          end
        end else if (cmd_valid && ready_exp(n)) begin
          int c;
          c = int'(cmd_ch);
          case (cmd_op)
            2'b01, 2'b10: begin
              if (cmd_period != 8'd0) begin
                mact[c] = 1'b1; rem[c] = int'(cmd_period); per[c] = int'(cmd_period);
                mper[c] = (cmd_op == 2'b10); clr_at[c] = -1;
              end else begin
                mact[c] = 1'b0; clr_at[c] = -1;
              end
            end
            2'b11: begin mact[c] = 1'b0; clr_at[c] = -1; end
            default: ;
          endcase
        end
        n = n + 1;
        for (int k = 0; k < NCH; k++) begin
          if (clr_at[k] == n) begin mact[k] = 1'b0; clr_at[k] = -1; end
        end
      end
    end
  end

  // Monitor: compares every cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("tick_1ms", int'(tick_1ms), int'(tick_exp(n)));
        chk("cmd_ready", int'(cmd_ready), int'(rst_n && ready_exp(n)));
        chk("active", int'(active), int'(mact));
        while (q.size() > 0 && q[0].n < n) begin
          compared++;
          mismatched++;
          $display("FAIL expire_missed: got none expected ch%0d at cycle %0d (now %0d)", q[0].ch, q[0].n, n);
          void'(q.pop_front());
        end
        if (expire != 4'd0) begin
          for (int k = 0; k < NCH; k++) if (expire[k]) obs[k]++;
          chk("expire_onehot", int'($onehot(expire)), 1);
          if (q.size() == 0) begin
            chk("expire_unexpected", int'(expire), 0);
          end else begin
            ev_t e;
            e = q.pop_front();
            chk("expire_cycle", n, e.n);
            chk("expire_ch", int'(expire), 1 << e.ch);
          end
        end
      end
    end
  end

  task automatic wait_tick();
    int c = 0;
    do begin @(negedge clk); c++; end while (!tick_1ms && c < 40);
    if (!tick_1ms) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_ticks(input int cnt);
    for (int i = 0; i < cnt; i++) wait_tick();
  endtask

  task automatic send_cmd(input logic [1:0] op, input int ch, input int p, output int waits);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = ch[1:0]; cmd_period = p[7:0];
    waits = 0;
    do begin @(negedge clk); waits++; end while (!cmd_ready && waits < 40);
    if (!cmd_ready) chk("cmd_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'b00;
  endtask

  task automatic first_tick_gap();
    int c = 0;
    do begin @(negedge clk); c++; end while (!tick_1ms && c < 40);
    chk("first_tick_gap", c - 1, PRE);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_ch = 2'd0; cmd_period = 8'd0;
    // 1: reset and prescaler cadence
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    first_tick_gap();
    wait_ticks(2);

    // 2: one-shot ch2 P=3
    base = obs[2];
    send_cmd(2'b01, 2, 3, w);
    wait_ticks(13);
    chk("oneshot_pulses", obs[2] - base, 1);

    // 3: periodic ch0 P=2, then stop
    base = obs[0];
    send_cmd(2'b10, 0, 2, w);
    wait_ticks(6);
    send_cmd(2'b11, 0, 0, w);
    wait_ticks(4);
    chk("periodic_pulses", obs[0] - base, 3);

    // 4: handshake held from the tick cycle
    wait_tick();
    send_cmd(2'b01, 3, 1, w);
    chk("handshake_wait", w, NCH + 1);
    wait_ticks(2);

    // 5: restart mid-count, zero-period start, all channels due on one tick
    base = obs[1];
    send_cmd(2'b01, 1, 8, w);
    wait_ticks(3);
    send_cmd(2'b01, 1, 5, w);
    wait_ticks(7);
    chk("restart_pulses", obs[1] - base, 1);
    send_cmd(2'b10, 1, 4, w);
    send_cmd(2'b10, 1, 0, w);
    base = obs[1];
    wait_ticks(6);
    chk("zero_period_pulses", obs[1] - base, 0);
    wait_tick();
    for (int k = 0; k < NCH; k++) send_cmd(2'b01, k, 1, w);
    wait_ticks(2);

    // 6: reset in the middle of a sweep with all channels due
    wait_tick();
    for (int k = 0; k < NCH; k++) send_cmd(2'b01, k, 1, w);
    wait_tick();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    first_tick_gap();
    wait_ticks(2);

    // 7: randomized commands
    for (int i = 0; i < 250; i++) begin
      send_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), w);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    for (int k = 0; k < NCH; k++) send_cmd(2'b11, k, 0, w);
    repeat (12) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
